uart_tx_channel: RTL and testbench
==================================

UART_TX_CHANNEL -- requirements
Module: uart_tx_channel

Interface
REQ-001 SHALL have parameter CLK_RATE, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 19200, line rate in bit/s; CLK_RATE/BAUD_RATE SHALL be >= 4.
REQ-003 SHALL have parameter DATA_BITS, default 8, payload width, legal range 5..9.
REQ-004 SHALL have parameter PARITY_MODE, default 1, where 0 = none, 1 = even, 2 = odd.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4, a power of two >= 2, used only when the FIFO is compiled in.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-009 SHALL have port tx_data, input, DATA_BITS bits, payload word.
REQ-010 SHALL have port tx_valid, input, 1 bit, word offered.
REQ-011 SHALL have port tx_ready, output, 1 bit, word accepted when tx_valid && tx_ready at a rising edge.
REQ-012 SHALL have port tx, output, 1 bit, registered serial line, idle high.
REQ-013 SHALL have port tx_busy, output, 1 bit, high while a frame is on the line or a word is pending.
REQ-014 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits, number of queued words.

Function
REQ-015 SHALL define the bit period as BIT_CYCLES = CLK_RATE/BAUD_RATE (integer division) clocks; the bit timer SHALL clear on every frame start.
REQ-016 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 SHALL transition IDLE->START when a word is available, START->DATA, DATA->PARITY (PARITY->STOP) after DATA_BITS bits, or DATA->STOP directly when PARITY_MODE=0.
REQ-018 SHALL hold START for 1 bit period with tx=0, and shall send data LSB first, 1 bit period per bit.
REQ-019 SHALL send the parity bit as the XOR of the payload for even parity, and as its inverse for odd parity.
REQ-020 SHALL hold STOP high for STOP_BITS bit periods.
REQ-021 At the end of STOP, SHALL enter START on the next cycle if a word is available (back-to-back frames, no idle gap); otherwise it SHALL enter IDLE.
REQ-022 SHALL drive the first start-bit cycle on tx one clock after the accepting edge in IDLE.
REQ-023 SHALL make the frame length exactly (1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS)*BIT_CYCLES clocks.
REQ-024 SHALL latch the payload at acceptance; later changes on tx_data SHALL NOT affect the frame in flight.
REQ-025 SHALL assert tx_busy when state != IDLE or fifo_count != 0.
REQ-026 SHALL ignore tx_valid while tx_ready is low; no word is lost or duplicated.

Reset
REQ-027 While rst is high: tx=1, tx_ready=0, tx_busy=0, fifo_count=0, state=IDLE, timer=0.
REQ-028 SHALL force tx high immediately on reset asserted mid-frame, discard the frame and all queued words, and transmit no partial remainder after release.
REQ-029 SHALL assert tx_ready on the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL support macro UART_TX_FIFO_EN.
REQ-031 With UART_TX_FIFO_EN defined: SHALL have a FIFO_DEPTH-entry FIFO, with tx_ready = !full and fifo_count = occupancy; a push and a pop in the same cycle SHALL leave the count unchanged; a push when full SHALL be impossible (ready low); a pop when empty SHALL not occur.
REQ-032 With UART_TX_FIFO_EN undefined: there SHALL be no FIFO, tx_ready SHALL be high only in IDLE (and not during reset), and fifo_count SHALL be constant 0.

Structure
REQ-033 Package uart_pkg SHALL hold the state enum typedef, the parity-mode constants (PARITY_NONE/EVEN/ODD), and the clog2 function.
REQ-034 Sub-module uart_tx_fifo SHALL implement the FIFO (synchronous, async-high reset) and SHALL be instantiated only under UART_TX_FIFO_EN.

Verification (CLK_RATE=100e6, BAUD_RATE=1e6, BIT_CYCLES=100)
REQ-035 Test: DATA_BITS=8, even parity, 1 stop, send 0xA5 -> tx low at accept+1 for 100 clocks, bits 1,0,1,0,0,1,0,1, parity 0, stop 1; total 1100 clocks.
REQ-036 Test: odd parity, 2 stops, DATA_BITS=7, send 0x7F -> parity bit 0, stop high 200 clocks, frame 1100 clocks.
REQ-037 Test: with FIFO_EN and depth 4, push 5 words back-to-back -> tx_ready low after the 4th push until the first frame starts; all 5 frames leave with no idle gap; fifo_count peaks at 4.
REQ-038 Test: without FIFO_EN, assert tx_valid in the same cycle STOP ends -> the word is accepted only in IDLE; tx_ready is low throughout the frame.
REQ-039 Test: assert rst 350 clocks into a 0x3C frame -> tx=1 in the same cycle, tx_busy=0, fifo_count=0, and no further edges on tx after release.
REQ-040 Test: PARITY_MODE=0, send 0x00 -> no parity slot; stop begins at clock 900.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit channel.
// State encoding, parity-mode constants and a constant-foldable clog2.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding words waiting for the transmitter.
// Push is dropped when full and pop is dropped when empty.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/uart_tx_channel.sv
// UART transmit channel: start, DATA_BITS payload LSB first, optional parity, stop bits.
// Define UART_TX_FIFO_EN to queue words in a FIFO_DEPTH-entry FIFO in front of the framer.
module uart_tx_channel
  import uart_pkg::*;
#(
  parameter int CLK_RATE    = 100_000_000,
  parameter int BAUD_RATE   = 19200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = PARITY_EVEN,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int BIT_CYCLES = CLK_RATE / BAUD_RATE;
  localparam int TW         = clog2(BIT_CYCLES);
  localparam int BW         = 4;

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 rdy_en_q;

  logic                 accept;
  logic                 bit_done;
  logic                 last_data;
  logic                 last_stop;
  logic                 stop_end;
  logic                 load_slot;
  logic                 load;
  logic                 word_avail;
  logic [DATA_BITS-1:0] load_word;

  assign accept    = tx_valid && tx_ready;
  assign bit_done  = (timer_q == TW'(BIT_CYCLES - 1));
  assign last_data = (bit_cnt_q == BW'(DATA_BITS - 1));
  assign last_stop = (bit_cnt_q == BW'(STOP_BITS - 1));
  assign stop_end  = (state_q == STOP) && bit_done && last_stop;
  // A new frame may only be loaded from IDLE or on the final cycle of STOP.
  assign load_slot = (state_q == IDLE) || stop_end;
  assign load      = load_slot && word_avail;

`ifdef UART_TX_FIFO_EN
  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DATA_BITS-1:0] fifo_head;

  // An empty FIFO is bypassed so the start bit is not delayed by a queue cycle.
  assign tx_ready   = rdy_en_q && !fifo_full;
  assign word_avail = !fifo_empty || accept;
  assign load_word  = fifo_empty ? tx_data : fifo_head;
  assign fifo_pop   = load_slot && !fifo_empty;
  assign fifo_push  = accept && !(load_slot && fifo_empty);

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (tx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );
`else
  assign tx_ready   = rdy_en_q && (state_q == IDLE);
  assign word_avail = accept;
  assign load_word  = tx_data;
  assign fifo_count = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (word_avail) state_d = START;
      START:  if (bit_done) state_d = DATA;
      DATA: begin
        if (bit_done && last_data) begin
          state_d = (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
        end
      end
      PARITY: if (bit_done) state_d = STOP;
      STOP:   if (stop_end) state_d = word_avail ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PARITY:  tx_d = par_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    if (load) begin
      timer_d   = '0;
      bit_cnt_d = '0;
      shift_d   = load_word;
      par_d     = (^load_word) ^ (PARITY_MODE == PARITY_ODD);
    end else if (state_q != IDLE) begin
      if (bit_done) begin
        timer_d   = '0;
        bit_cnt_d = '0;
        if (state_q == DATA) begin
          shift_d = shift_q >> 1;
          if (!last_data) begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else if ((state_q == STOP) && !last_stop) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      rdy_en_q  <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      rdy_en_q  <= 1'b1;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_channel.sv
// Directed bench for uart_tx_channel at 100 MHz / 1 Mbaud (100 clocks per bit).
// Three instances cover 8E1, 7O2 and 8N1; FIFO checks compile in with UART_TX_FIFO_EN.
module tb_uart_tx_channel;

  localparam int CLK  = 100_000_000;
  localparam int BAUD = 1_000_000;
`ifdef UART_TX_FIFO_EN
  localparam bit FIFO_ON = 1'b1;
`else
  localparam bit FIFO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] a_data = 8'h00;
  logic       a_valid = 1'b0;
  logic       a_ready, a_tx, a_busy;
  logic [2:0] a_cnt;

  logic [6:0] b_data = 7'h00;
  logic       b_valid = 1'b0;
  logic       b_ready, b_tx, b_busy;
  logic [2:0] b_cnt;

  logic [7:0] c_data = 8'h00;
  logic       c_valid = 1'b0;
  logic       c_ready, c_tx, c_busy;
  logic [2:0] c_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic       cap_tx   [5600];
  logic       cap_busy [5600];
  logic       cap_rdy  [5600];
  logic [2:0] cap_cnt  [5600];

  always #5 clk = ~clk;

  uart_tx_channel #(.CLK_RATE(CLK), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY_MODE(1),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
    .tx(a_tx), .tx_busy(a_busy), .fifo_count(a_cnt));

  uart_tx_channel #(.CLK_RATE(CLK), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY_MODE(2),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
    .tx(b_tx), .tx_busy(b_busy), .fifo_count(b_cnt));

  uart_tx_channel #(.CLK_RATE(CLK), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY_MODE(0),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst(rst), .tx_data(c_data), .tx_valid(c_valid), .tx_ready(c_ready),
    .tx(c_tx), .tx_busy(c_busy), .fifo_count(c_cnt));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  // Index i holds outputs sampled on the negedge after the i-th rising edge from the call.
  task automatic capture(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case (which)
        0: begin cap_tx[i] = a_tx; cap_busy[i] = a_busy; cap_rdy[i] = a_ready; cap_cnt[i] = a_cnt; end
        1: begin cap_tx[i] = b_tx; cap_busy[i] = b_busy; cap_rdy[i] = b_ready; cap_cnt[i] = b_cnt; end
        default: begin cap_tx[i] = c_tx; cap_busy[i] = c_busy; cap_rdy[i] = c_ready; cap_cnt[i] = c_cnt; end
      endcase
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (a_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, required 1", a_tx); end
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, required 0", a_ready); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", a_busy); end
    n_checks++; if (a_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d, required 0", a_cnt); end
    n_checks++; if ({b_tx, c_tx} !== 2'b11) begin n_fail++; $display("FAIL reset_tx_bc: got %b, required 11", {b_tx, c_tx}); end
    rst = 1'b0;
    #1;
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b, required 0", a_ready); end
    @(negedge clk);
    n_checks++; if ({a_ready, b_ready, c_ready} !== 3'b111) begin
      n_fail++; $display("FAIL ready_after_release: got %b, required 111", {a_ready, b_ready, c_ready});
    end
    $display("test_reset: done");
  endtask

  task automatic test_frame_a5();
    logic [15:0] e;
    int          bad;
    e = 16'h054A;  // slots 0..10: start, A5 LSB first, parity 0, stop
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL a5_ready: got %b, required 1", a_ready); end
    a_data  = 8'hA5;
    a_valid = 1'b1;
    fork
      capture(0, 1205);
      begin @(negedge clk); a_valid = 1'b0; a_data = 8'h5A; end
    join
    n_checks++; if (cap_tx[0] !== 1'b1) begin n_fail++; $display("FAIL a5_accept_cycle: tx %b, required 1", cap_tx[0]); end
    for (int s = 0; s < 11; s++) begin
      bad = 0;
      for (int j = 0; j < 100; j++) if (cap_tx[1 + 100 * s + j] !== e[s]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL a5_slot%0d: %0d of 100 samples differ, required tx=%b", s, bad, e[s]); end
    end
    n_checks++; if (cap_busy[1099] !== 1'b1) begin n_fail++; $display("FAIL a5_busy_last: got %b, required 1", cap_busy[1099]); end
    n_checks++; if (cap_busy[1100] !== 1'b0) begin n_fail++; $display("FAIL a5_busy_end: got %b, required 0", cap_busy[1100]); end
    $display("test_frame_a5: frame 0xA5 8E1 sent");
  endtask

  task automatic test_odd_two_stop();
    logic [15:0] e;
    int          bad;
    e = 16'h06FE;  // start, 7 ones, odd parity 0, two stops
    b_data  = 7'h7F;
    b_valid = 1'b1;
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL b_ready: got %b, required 1", b_ready); end
    fork
      capture(1, 1205);
      begin @(negedge clk); b_valid = 1'b0; b_data = 7'h00; end
    join
    for (int s = 0; s < 9; s++) begin
      bad = 0;
      for (int j = 0; j < 100; j++) if (cap_tx[1 + 100 * s + j] !== e[s]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL b_slot%0d: %0d of 100 samples differ, required tx=%b", s, bad, e[s]); end
    end
    bad = 0;
    for (int j = 901; j < 1101; j++) if (cap_tx[j] !== 1'b1) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b_stop200: %0d samples low, required 0", bad); end
    n_checks++; if (cap_busy[1099] !== 1'b1) begin n_fail++; $display("FAIL b_busy_last: got %b, required 1", cap_busy[1099]); end
    n_checks++; if (cap_busy[1100] !== 1'b0) begin n_fail++; $display("FAIL b_busy_end: got %b, required 0", cap_busy[1100]); end
    $display("test_odd_two_stop: frame 0x7F 7O2 sent");
  endtask

  task automatic test_no_parity();
    logic [15:0] e;
    int          bad;
    e = 16'h0200;  // start, eight zeros, stop in slot 9
    c_data  = 8'h00;
    c_valid = 1'b1;
    fork
      capture(2, 1105);
      begin @(negedge clk); c_valid = 1'b0; c_data = 8'hFF; end
    join
    for (int s = 0; s < 10; s++) begin
      bad = 0;
      for (int j = 0; j < 100; j++) if (cap_tx[1 + 100 * s + j] !== e[s]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL c_slot%0d: %0d of 100 samples differ, required tx=%b", s, bad, e[s]); end
    end
    n_checks++; if (cap_tx[900] !== 1'b0) begin n_fail++; $display("FAIL c_clk899: got %b, required 0", cap_tx[900]); end
    n_checks++; if (cap_tx[901] !== 1'b1) begin n_fail++; $display("FAIL c_clk900_stop: got %b, required 1", cap_tx[901]); end
    n_checks++; if (cap_busy[999] !== 1'b1) begin n_fail++; $display("FAIL c_busy_last: got %b, required 1", cap_busy[999]); end
    n_checks++; if (cap_busy[1000] !== 1'b0) begin n_fail++; $display("FAIL c_busy_end: got %b, required 0", cap_busy[1000]); end
    $display("test_no_parity: frame 0x00 8N1 sent");
  endtask

  task automatic test_stop_handoff();
    logic [15:0] e;
    int          bad;
    int          tries;
    int          o2;
    logic        acc;
    e     = 16'h0602;  // 0x01: start, 1 then seven zeros, even parity 1, stop
    tries = 0;
    acc   = 1'b0;
    a_data  = 8'h96;
    a_valid = 1'b1;
    fork
      capture(0, 2300);
      begin
        @(negedge clk);
        a_valid = 1'b0;
        repeat (1099) @(negedge clk);
        a_data  = 8'h01;
        a_valid = 1'b1;
        while (!acc && tries < 5) begin
          acc = a_ready;
          tries++;
          @(negedge clk);
        end
        a_valid = 1'b0;
      end
    join
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL handoff_accept: accepted=%b after %0d cycles, required 1", acc, tries); end
`ifndef UART_TX_FIFO_EN
    bad = 0;
    for (int j = 0; j < 1100; j++) if (cap_rdy[j] !== 1'b0) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ready_in_frame: high for %0d cycles, required 0", bad); end
    n_checks++; if (cap_busy[1100] !== 1'b0) begin n_fail++; $display("FAIL handoff_idle_gap: busy %b, required 0", cap_busy[1100]); end
`endif
    n_checks++; if (cap_rdy[1100] !== 1'b1) begin n_fail++; $display("FAIL handoff_ready: got %b, required 1", cap_rdy[1100]); end
    n_checks++; if (cap_tx[1101] !== !FIFO_ON) begin n_fail++; $display("FAIL handoff_tx1101: got %b, required %b", cap_tx[1101], !FIFO_ON); end
    o2 = FIFO_ON ? 1101 : 1102;
    for (int s = 0; s < 11; s++) begin
      bad = 0;
      for (int j = 0; j < 100; j++) if (cap_tx[o2 + 100 * s + j] !== e[s]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL handoff_slot%0d: %0d of 100 samples differ, required tx=%b", s, bad, e[s]); end
    end
    $display("test_stop_handoff: frames 0x96, 0x01 sent");
  endtask

`ifdef UART_TX_FIFO_EN
  task automatic test_fifo_burst();
    logic [7:0]  w [5];
    logic        p [5];
    logic [10:0] f;
    int          miss;
    int          low;
    int          peak;
    w = '{8'h11, 8'h23, 8'h37, 8'h40, 8'h5A};
    p = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    miss = 0;
    fork
      capture(0, 5505);
      begin
        a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
          a_data = w[i];
          if (a_ready !== 1'b1) miss++;
          @(negedge clk);
        end
        a_valid = 1'b0;
      end
    join
    n_checks++; if (miss != 0) begin n_fail++; $display("FAIL burst_ready: low on %0d pushes, required 0", miss); end
    n_checks++; if (cap_cnt[4] !== 3'd4) begin n_fail++; $display("FAIL burst_count: got %0d, required 4", cap_cnt[4]); end
    n_checks++; if (cap_rdy[4] !== 1'b0) begin n_fail++; $display("FAIL burst_full_ready: got %b, required 0", cap_rdy[4]); end
    n_checks++; if (cap_rdy[1099] !== 1'b0) begin n_fail++; $display("FAIL burst_ready_hold: got %b, required 0", cap_rdy[1099]); end
    n_checks++; if (cap_rdy[1100] !== 1'b1) begin n_fail++; $display("FAIL burst_ready_pop: got %b, required 1", cap_rdy[1100]); end
    n_checks++; if (cap_cnt[1100] !== 3'd3) begin n_fail++; $display("FAIL burst_count_pop: got %0d, required 3", cap_cnt[1100]); end
    peak = 0;
    low  = 0;
    for (int j = 0; j < 5500; j++) begin
      if (int'(cap_cnt[j]) > peak) peak = int'(cap_cnt[j]);
      if (cap_busy[j] !== 1'b1) low++;
    end
    n_checks++; if (peak != 4) begin n_fail++; $display("FAIL burst_peak: got %0d, required 4", peak); end
    n_checks++; if (low != 0) begin n_fail++; $display("FAIL burst_gap: busy low %0d cycles, required 0", low); end
    n_checks++; if (cap_busy[5500] !== 1'b0) begin n_fail++; $display("FAIL burst_busy_end: got %b, required 0", cap_busy[5500]); end
    for (int i = 0; i < 5; i++) begin
      for (int s = 0; s < 11; s++) f[s] = cap_tx[1 + 1100 * i + 100 * s + 50];
      n_checks++;
      if (f !== {1'b1, p[i], w[i], 1'b0}) begin
        n_fail++; $display("FAIL burst_frame%0d: got %b, required %b", i, f, {1'b1, p[i], w[i], 1'b0});
      end
    end
    $display("test_fifo_burst: five queued frames sent");
  endtask
`endif

  task automatic test_reset_midframe();
    int   off;
    logic pre;
    int   low;
    int   busy_hi;
    for (int r = 0; r < 2; r++) begin
      off = (r == 0) ? 350 : 150;
      pre = (r == 0) ? 1'b1 : 1'b0;
      n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL rst%0d_ready_start: got %b, required 1", off, a_ready); end
      a_data  = 8'h3C;
      a_valid = 1'b1;
      @(negedge clk);
      a_data = 8'h66;
      @(negedge clk);
      a_data = 8'h77;
      @(negedge clk);
      a_valid = 1'b0;
      repeat (off - 2) @(negedge clk);
      n_checks++; if (a_tx !== pre) begin n_fail++; $display("FAIL rst%0d_pre_tx: got %b, required %b", off, a_tx, pre); end
      rst = 1'b1;
      #1;
      n_checks++; if (a_tx !== 1'b1) begin n_fail++; $display("FAIL rst%0d_tx: got %b, required 1", off, a_tx); end
      n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst%0d_busy: got %b, required 0", off, a_busy); end
      n_checks++; if (a_cnt !== 3'd0) begin n_fail++; $display("FAIL rst%0d_count: got %0d, required 0", off, a_cnt); end
      n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL rst%0d_ready: got %b, required 0", off, a_ready); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      low     = 0;
      busy_hi = 0;
      for (int i = 0; i < 1500; i++) begin
        @(negedge clk);
        if (a_tx !== 1'b1) low++;
        if (a_busy !== 1'b0) busy_hi++;
      end
      n_checks++; if (low != 0) begin n_fail++; $display("FAIL rst%0d_residue_tx: low %0d cycles, required 0", off, low); end
      n_checks++; if (busy_hi != 0) begin n_fail++; $display("FAIL rst%0d_residue_busy: high %0d cycles, required 0", off, busy_hi); end
      $display("test_reset_midframe: reset %0d clocks into 0x3C frame", off);
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_odd_two_stop();
    test_no_parity();
    test_stop_handoff();
`ifdef UART_TX_FIFO_EN
    test_fifo_burst();
`endif
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
